// File: rtl/pipe_mux_reg_pkg.sv
// Shared definitions for the selector/stage-register slice: the default
// datapath width, the select-width rule and the packing offsets used for
// the flattened d, s and y buses.
package pipe_pkg;

  // Datapath width used by default throughout the pipeline.
  localparam int DEFAULT_WIDTH = 32;

  // Select width for an N-input mux. Never less than one bit.
  function automatic int sel_w_f(input int num_in);
    int w;
    w = $clog2(num_in);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

  // LSB of channel c, input i inside the flattened data bus.
  function automatic int d_lsb(input int c, input int i, input int num_in, input int width);
    return (c * num_in + i) * width;
  endfunction

  // LSB of channel c inside the flattened select bus.
  function automatic int s_lsb(input int c, input int sel_w);
    return c * sel_w;
  endfunction

  // LSB of channel c inside the flattened output bus.
  function automatic int y_lsb(input int c, input int width);
    return c * width;
  endfunction

endpackage

// File: rtl/pipe_mux_reg_muxn.sv
// Combinational N-input selector. A select value beyond the last input
// falls back to the last input (so a 3-input mux with s = 3 returns d2),
// and the condition is reported on oor for the caller to track.
module muxn
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NUM_IN = 3,
  localparam int SEL_W = sel_w_f(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]        s,
  output logic [WIDTH-1:0]        y,
  output logic                    oor
);

  logic [31:0] w_s_ext;

  assign w_s_ext = 32'(s);

  // Pick the addressed input, or the last input when the select overshoots.
  always_comb begin
    y   = d[(NUM_IN-1)*WIDTH +: WIDTH];
    oor = 1'b0;
    if (w_s_ext < 32'(NUM_IN)) begin
      y = d[w_s_ext*WIDTH +: WIDTH];
    end else begin
      oor = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_mux_reg.sv
// Multi-channel N-input selector fused with a pipeline stage register.
// Each channel picks one of its inputs; the results are captured with
// stall (en) and flush (clr) control, alongside a valid bit and a sticky
// flag recording any out-of-range select seen on a valid capture.
module pipe_mux_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NUM_IN = 3,
  parameter int NUM_CH = 2,
  localparam int SEL_W = sel_w_f(NUM_IN)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           clr,
  input  logic                           in_valid,
  input  logic [NUM_CH*NUM_IN*WIDTH-1:0] d,
  input  logic [NUM_CH*SEL_W-1:0]        s,
  output logic [NUM_CH*WIDTH-1:0]        y,
  output logic                           out_valid,
  output logic                           sel_err
);

  logic [NUM_CH*WIDTH-1:0] w_sel;
  logic [NUM_CH-1:0]       w_oor;
  logic                    w_capture;
  logic                    w_err_set;

  logic [NUM_CH*WIDTH-1:0] r_y;
  logic                    r_valid;
  logic                    r_sel_err;

  // One selector per channel; channels share nothing but the clock.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    muxn #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN)
    ) u_mux (
      .d   (d[d_lsb(c, 0, NUM_IN, WIDTH) +: NUM_IN*WIDTH]),
      .s   (s[s_lsb(c, SEL_W) +: SEL_W]),
      .y   (w_sel[y_lsb(c, WIDTH) +: WIDTH]),
      .oor (w_oor[c])
    );
  end

  // A capture edge is an enabled, non-flushed edge; only those may flag errors.
  assign w_capture = en & ~clr;
  assign w_err_set = w_capture & in_valid & (|w_oor);

  // Stage register: reset, then flush (which beats a stall), then capture, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_y     <= '0;
      r_valid <= 1'b0;
    end else if (clr) begin
      r_y     <= '0;
      r_valid <= 1'b0;
    end else if (en) begin
      r_y     <= w_sel;
      r_valid <= in_valid;
    end else begin
      r_y     <= r_y;
      r_valid <= r_valid;
    end
  end

  // Sticky out-of-range flag; only reset clears it, a flush leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel_err <= 1'b0;
    end else if (w_err_set) begin
      r_sel_err <= 1'b1;
    end else begin
      r_sel_err <= r_sel_err;
    end
  end

  assign y         = r_y;
  assign out_valid = r_valid;
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_pipe_mux_reg.sv
// Scoreboard bench for pipe_mux_reg. The driver pushes the expected stage
// contents for every edge it drives; per-DUT monitors pop and compare just
// after each rising edge. A second instance (NUM_IN = 4, NUM_CH = 1,
// WIDTH = 8) is swept with random en/clr against a small reference model.
module tb_pipe_mux_reg;

  typedef struct packed {
    logic [31:0] y0;
    logic [31:0] y1;
    logic        ov;
    logic        se;
  } exp1_t;

  typedef struct packed {
    logic [7:0] y;
    logic       ov;
  } exp2_t;

  logic clk = 1'b0;
  logic reset;

  // Main instance: WIDTH 32, NUM_IN 3, NUM_CH 2
  logic         en, clr, in_valid;
  logic [191:0] d;
  logic [3:0]   s;
  logic [63:0]  y;
  logic         out_valid, sel_err;

  // Sweep instance: WIDTH 8, NUM_IN 4, NUM_CH 1
  logic        en2, clr2, iv2;
  logic [31:0] d2;
  logic [1:0]  s2;
  logic [7:0]  y2;
  logic        ov2, se2;

  exp1_t q1[$];
  exp2_t q2[$];

  int total = 0;
  int bad = 0;

  logic [7:0] m_y;
  logic       m_v;

  pipe_mux_reg #(.WIDTH(32), .NUM_IN(3), .NUM_CH(2)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .in_valid(in_valid),
    .d(d), .s(s), .y(y), .out_valid(out_valid), .sel_err(sel_err)
  );

  pipe_mux_reg #(.WIDTH(8), .NUM_IN(4), .NUM_CH(1)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .clr(clr2), .in_valid(iv2),
    .d(d2), .s(s2), .y(y2), .out_valid(ov2), .sel_err(se2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step1(input logic rs, input logic e, input logic c, input logic v,
                       input logic [1:0] s0v, input logic [1:0] s1v,
                       input logic [31:0] ey0, input logic [31:0] ey1,
                       input logic eov, input logic ese);
    exp1_t ex;
    @(negedge clk);
    reset    = rs;
    en       = e;
    clr      = c;
    in_valid = v;
    s        = {s1v, s0v};
    ex.y0 = ey0; ex.y1 = ey1; ex.ov = eov; ex.se = ese;
    q1.push_back(ex);
  endtask

  // Monitor for the main instance
  initial begin
    exp1_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (q1.size() > 0) begin
        ex = q1.pop_front();
        chk("y0", y[31:0], ex.y0);
        chk("y1", y[63:32], ex.y1);
        chk("out_valid", 32'(out_valid), 32'(ex.ov));
        chk("sel_err", 32'(sel_err), 32'(ex.se));
      end
    end
  end

  // Monitor for the sweep instance
  initial begin
    exp2_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (q2.size() > 0) begin
        ex = q2.pop_front();
        chk("sweep_y", 32'(y2), 32'(ex.y));
        chk("sweep_valid", 32'(ov2), 32'(ex.ov));
        chk("sweep_sel_err", 32'(se2), 32'd0);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver
  initial begin
    exp2_t ex2;
    reset = 1'b1; en = 1'b0; clr = 1'b0; in_valid = 1'b0; s = 4'd0;
    d  = {32'h0000000C, 32'h0000000B, 32'h0000000A, 32'h00000033, 32'h00000022, 32'h00000011};
    en2 = 1'b0; clr2 = 1'b0; iv2 = 1'b0; s2 = 2'd0;
    d2 = {8'h08, 8'h04, 8'h02, 8'h01};
    m_y = 8'h00; m_v = 1'b0;

    //    rs    en    clr   iv    s0    s1    y0             y1             ov    se
    step1(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
    step1(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 2'd2, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
    // capture with one-cycle latency
    step1(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd2, 32'h00000022, 32'h0000000C, 1'b1, 1'b0);
    // stall for three cycles while s0 changes
    step1(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 32'h00000022, 32'h0000000C, 1'b1, 1'b0);
    step1(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 32'h00000022, 32'h0000000C, 1'b1, 1'b0);
    step1(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 32'h00000022, 32'h0000000C, 1'b1, 1'b0);
    step1(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd2, 32'h00000011, 32'h0000000C, 1'b1, 1'b0);
    // flush beats stall
    step1(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd2, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
    step1(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd2, 32'h00000022, 32'h0000000C, 1'b0, 1'b0);
    // out-of-range while invalid: fallback data, no flag
    step1(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd3, 32'h00000033, 32'h0000000C, 1'b0, 1'b0);
    // out-of-range on flushed and stalled edges: no flag
    step1(1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 2'd0, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
    step1(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
    // out-of-range on a valid capture sets the sticky flag
    step1(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 2'd0, 32'h00000033, 32'h0000000A, 1'b1, 1'b1);
    step1(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd1, 32'h00000011, 32'h0000000B, 1'b1, 1'b1);
    // reset while capturing wins, then normal capture resumes
    step1(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 2'd1, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
    step1(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 2'd1, 32'h00000033, 32'h0000000B, 1'b1, 1'b0);
    step1(1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 2'd1, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
    step1(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0, 32'h00000022, 32'h0000000A, 1'b1, 1'b0);

    // Sweep the power-of-two instance; main instance stalls.
    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (k > 0) @(negedge clk);
      en2  = ($urandom_range(0, 3) != 0);
      clr2 = ($urandom_range(0, 7) == 0);
      iv2  = 1'($urandom_range(0, 1));
      s2   = 2'($urandom_range(0, 3));
      if (clr2) begin
        m_y = 8'h00;
        m_v = 1'b0;
      end else if (en2) begin
        m_y = 8'h01 << s2;
        m_v = iv2;
      end
      ex2.y = m_y; ex2.ov = m_v;
      q2.push_back(ex2);
    end

    @(negedge clk);
    en2 = 1'b0; clr2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
